sd_image_reader: RTL

SD_IMAGE_READER -- requirements
Module: sd_image_reader

---
 rtl/sd_image_pkg.sv | 25 ++
 rtl/sd_busy_edge.sv | 26 ++
 rtl/sd_image_reader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sd_image_pkg.sv
// Shared constants and state encoding for the SD image reader/writer pair.
// The sector address helper is the single definition of the image layout on the card.
package sd_image_pkg;

  localparam int unsigned SEC_LENGTH_DEF = 2000;
  localparam int unsigned INDEX_SEC_DEF  = 0;
  localparam int unsigned SEC_WORDS_DEF  = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_IDX     = 3'd1,
    ST_WAIT_SPACE = 3'd2,
    ST_RD_SEC     = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  // Image n occupies sectors n*len+1 .. n*len+len; sector 0 region holds the index.
  function automatic logic [31:0] sec_addr(input logic [15:0] idx,
                                           input logic [11:0] k,
                                           input logic [31:0] len);
    return ({16'd0, idx} * len) + 32'd1 + {20'd0, k};
  endfunction

endpackage

// File: rtl/sd_busy_edge.sv
// Two-flop delay of an SD engine busy flag and its falling-edge detect.
// Shared by the image reader (rd_busy) and writer (wr_busy).
module sd_busy_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic neg_edge
);

  logic d0;
  logic d1;

  // Delay line for the busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      d0 <= busy;
      d1 <= d0;
    end
  end

  assign neg_edge = d1 & ~d0;

endmodule

// File: rtl/sd_image_reader.sv
// Reads the image-count index sector, then streams every sector of the latest
// stored image into the downstream 16w32r FIFO, throttled by FIFO space.
module sd_image_reader
  import sd_image_pkg::*;
#(
  parameter int unsigned SEC_LENGTH = SEC_LENGTH_DEF,
  parameter int unsigned INDEX_SEC  = INDEX_SEC_DEF,
  parameter int unsigned SEC_WORDS  = SEC_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        sys_image_read_req,
  input  logic        rd_busy,
  input  logic [15:0] rd_data,
  input  logic        rd_data_valid,
  input  logic [9:0]  fifo_16w32r_len,
  input  logic        fifo_16w32r_full,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic [15:0] image_index,
  output logic        rd_image_busy,
  output logic        rd_image_done,
  output logic        rd_image_err,
  output logic [2:0]  o_state
);

  localparam logic [31:0] LEN_LIMIT  = 32'(FIFO_DEPTH - SEC_WORDS);
  localparam logic [12:0] SEC_LEN_W  = 13'(SEC_LENGTH);
  localparam logic [31:0] INDEX_ADDR = 32'(INDEX_SEC);
  localparam logic [31:0] SEC_LEN_32 = 32'(SEC_LENGTH);

  state_e      state;
  state_e      next_state;
  logic        neg_rd_busy;
  logic [11:0] sec_cnt;
  logic [15:0] idx_word;
  logic        idx_seen;
  logic        len_ok;

  logic        start_s;
  logic [31:0] addr_s;
  logic        wr_s;
  logic        set_err_s;
  logic        clr_err_s;
  logic        idx_load_s;
  logic        cnt_inc_s;

  sd_busy_edge u_busy_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (rd_busy),
    .neg_edge (neg_rd_busy)
  );

  assign len_ok        = ({22'd0, fifo_16w32r_len} <= LEN_LIMIT);
  assign rd_image_busy = (state != ST_IDLE);
  assign o_state       = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle strobes; losing card init overrides everything.
  always_comb begin
    next_state = state;
    start_s    = 1'b0;
    addr_s     = 32'd0;
    wr_s       = 1'b0;
    set_err_s  = 1'b0;
    clr_err_s  = 1'b0;
    idx_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    if (!sd_init_done) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sys_image_read_req && !rd_busy) begin
            next_state = ST_RD_IDX;
            start_s    = 1'b1;
            addr_s     = INDEX_ADDR;
            clr_err_s  = 1'b1;
          end
        end
        ST_RD_IDX: begin
          if (neg_rd_busy) begin
            if (idx_word == 16'd0) begin
              set_err_s  = 1'b1;
              next_state = ST_IDLE;
            end else begin
              idx_load_s = 1'b1;
              next_state = ST_WAIT_SPACE;
            end
          end
        end
        ST_WAIT_SPACE: begin
          if (!rd_busy && !fifo_16w32r_full && len_ok) begin
            start_s    = 1'b1;
            addr_s     = sec_addr(image_index, sec_cnt, SEC_LEN_32);
            next_state = ST_RD_SEC;
          end
        end
        ST_RD_SEC: begin
          wr_s      = rd_data_valid;
          set_err_s = rd_data_valid & fifo_16w32r_full;
          if (neg_rd_busy) begin
            cnt_inc_s  = 1'b1;
            next_state = (({1'b0, sec_cnt} + 13'd1) == SEC_LEN_W) ? ST_DONE : ST_WAIT_SPACE;
          end
        end
        ST_DONE: begin
          next_state = ST_IDLE;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs, index capture and sector counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_start_en   <= 1'b0;
      rd_sec_addr   <= 32'd0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= 16'd0;
      rd_image_done <= 1'b0;
      rd_image_err  <= 1'b0;
      image_index   <= 16'd0;
      sec_cnt       <= 12'd0;
      idx_word      <= 16'd0;
      idx_seen      <= 1'b0;
    end else begin
      rd_start_en   <= start_s;
      fifo_wr_en    <= wr_s;
      rd_image_done <= (next_state == ST_DONE);
      if (start_s) begin
        rd_sec_addr <= addr_s;
      end
      if (wr_s) begin
        fifo_wr_data <= rd_data;
      end
      if (clr_err_s) begin
        rd_image_err <= 1'b0;
      end else if (set_err_s) begin
        rd_image_err <= 1'b1;
      end
      if (idx_load_s) begin
        image_index <= idx_word - 16'd1;
        sec_cnt     <= 12'd0;
      end else if (cnt_inc_s) begin
        sec_cnt <= sec_cnt + 12'd1;
      end
      // Only the first word of the index sector carries the image count.
      if (clr_err_s) begin
        idx_word <= 16'd0;
        idx_seen <= 1'b0;
      end else if (state == ST_RD_IDX && rd_data_valid && !idx_seen) begin
        idx_word <= rd_data;
        idx_seen <= 1'b1;
      end
    end
  end

endmodule
